frame_writer: RTL and testbench
===============================

Name: frame_writer

Overview:
- Write-side companion to the frame-buffer read address path.
- Accepts a host pixel stream of one colour component per beat and generates RAM write strobes.
- Write address = color + 3*angle + 3*NB_ANGLES*row, in logical angles (no PCB offset applied on write).
- Frame buffer is double-buffered: frames are written into bank w_bank while the display reads bank ~w_bank. Banks swap at frame completion, gated by bank_lock.

Parameters:
- ADDR_WIDTH, 14, RAM address width per bank; 3*NB_ANGLES*NB_ROWS <= 2**ADDR_WIDTH is required.
- ROW_WIDTH, 5, row index width.
- NB_ROWS, 32, rows per frame.
- NB_ANGLES, 128, angles per revolution; ANGLE_WIDTH = $clog2(NB_ANGLES).
- DATA_WIDTH, 8, colour component width.

Ports:
- clk  in  1  system clock
- nrst  in  1  synchronous active-low reset
- in_data  in  DATA_WIDTH  component value
- in_sof  in  1  marks first beat of a frame; qualified by in_valid
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid&in_ready
- bank_lock  in  1  display forbids bank swap while high
- w_en  out  1  RAM write strobe
- w_addr  out  ADDR_WIDTH  RAM write address within bank
- w_data  out  DATA_WIDTH  RAM write data
- w_bank  out  1  bank being written; display reads ~w_bank
- frame_done  out  1  one-cycle pulse on bank swap
- sync_err  out  1  one-cycle pulse on sof received mid-frame

Behaviour:
- Reset (nrst=0 at clk edge): state IDLE, color/angle/row counters = 0, address counter = 0, w_en=0, w_addr=0, w_data=0, w_bank=0, frame_done=0, sync_err=0. Reset mid-frame discards the partial frame; bank is not swapped.
- Counters: color 0..2 increments fastest; angle 0..NB_ANGLES-1 increments on color wrap; row 0..NB_ROWS-1 increments on angle wrap. Address counter increments by 1 per accepted beat and must equal color + 3*angle + 3*NB_ANGLES*row, computed in ADDR_WIDTH bits.
- Output latency is 1 cycle. An accepted beat at edge N gives, after edge N: w_en=1, w_addr = address of that beat, w_data = in_data. Otherwise w_en=0, and w_addr/w_data hold their values.
- IDLE:
  - in_ready=1.
  - Beats without in_sof are consumed and dropped (w_en stays 0).
  - A beat with in_sof is written at address 0; counters advance to address 1; state goes to WRITE.
- WRITE:
  - in_ready=1.
  - Each accepted beat is written at the current address, then counters advance.
  - Beat with in_sof: sync_err pulses for 1 cycle; the beat is written at address 0; counters restart at address 1; state stays WRITE; no bank swap.
  - Last beat (color=2, angle=NB_ANGLES-1, row=NB_ROWS-1) is written normally; counters reset to 0; state goes to SWAP.
- SWAP:
  - in_ready=0.
  - When bank_lock=0: w_bank toggles, frame_done pulses for 1 cycle (same edge as the toggle), state goes to IDLE.
  - When bank_lock=1: wait indefinitely.
- The w_en of the last beat and the w_bank toggle never occur on the same edge; the last write always lands in the old bank.
- in_valid=0 in any state: no counter change, no write.
- in_data and in_sof are ignored when in_valid=0.

Test Plan:
- Reset, then sof beat 0xAA followed by 2 beats (0x11, 0x22) -> w_en 3 cycles, w_addr 0,1,2, w_data AA,11,22, w_bank=0.
- Full frame, NB_ANGLES=4, NB_ROWS=2 (24 beats), bank_lock=0:
  - beat 3 -> w_addr 3 (angle 1, color 0); beat 12 -> w_addr 12 (row 1).
  - After beat 23 (addr 23), 1 cycle in SWAP with in_ready=0; w_bank 0->1 with frame_done pulse; back to IDLE.
- bank_lock=1 held 10 cycles at frame end -> in_ready=0 for 10 cycles, no frame_done. Release -> next edge w_bank toggles and frame_done=1.
- Beats without sof in IDLE (5 beats) -> no w_en. Then sof beat -> w_addr 0.
- Mid-frame sof at address 7 -> sync_err pulse, write at w_addr 0, next beat at w_addr 1, w_bank unchanged.
- nrst=0 asserted at address 10, then released -> all outputs zero, state IDLE, w_bank=0. Non-sof beats are dropped until the next sof.

Source files
------------

// File: rtl/frame_writer_if.sv
// Host pixel stream, bank control and RAM write port of the frame writer.
// The master side is the host/display; the slave side is frame_writer.
interface frame_writer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 14
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_sof;
  logic                  in_valid;
  logic                  in_ready;
  logic                  bank_lock;
  logic                  w_en;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_bank;
  logic                  frame_done;
  logic                  sync_err;

  modport master (
    output in_data, in_sof, in_valid, bank_lock,
    input  in_ready, w_en, w_addr, w_data, w_bank, frame_done, sync_err
  );

  modport slave (
    input  in_data, in_sof, in_valid, bank_lock,
    output in_ready, w_en, w_addr, w_data, w_bank, frame_done, sync_err
  );
endinterface

// File: rtl/frame_writer.sv
// Writes a host colour-component stream into one bank of a double-buffered
// frame RAM, swapping banks at frame end unless the display holds bank_lock.
module frame_writer #(
  parameter int ADDR_WIDTH = 14,
  parameter int ROW_WIDTH  = 5,
  parameter int NB_ROWS    = 32,
  parameter int NB_ANGLES  = 128,
  parameter int DATA_WIDTH = 8
) (
  input logic             clk,
  input logic             nrst,
  frame_writer_if.slave   bus
);

  localparam int ANGLE_WIDTH = (NB_ANGLES > 1) ? $clog2(NB_ANGLES) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_SWAP  = 2'd2;

  localparam logic [ANGLE_WIDTH-1:0] ANGLE_LAST = ANGLE_WIDTH'(NB_ANGLES - 1);
  localparam logic [ROW_WIDTH-1:0]   ROW_LAST   = ROW_WIDTH'(NB_ROWS - 1);

  logic [1:0]             state_reg;
  logic [1:0]             color_reg;
  logic [ANGLE_WIDTH-1:0] angle_reg;
  logic [ROW_WIDTH-1:0]   row_reg;
  logic [ADDR_WIDTH-1:0]  addr_reg;
  logic                   w_en_reg;
  logic [ADDR_WIDTH-1:0]  w_addr_reg;
  logic [DATA_WIDTH-1:0]  w_data_reg;
  logic                   w_bank_reg;
  logic                   frame_done_reg;
  logic                   sync_err_reg;
  logic                   accept;
  logic                   last_beat;

  assign bus.in_ready   = (state_reg != S_SWAP);
  assign accept         = bus.in_valid & bus.in_ready;
  assign last_beat      = (color_reg == 2'd2) && (angle_reg == ANGLE_LAST) && (row_reg == ROW_LAST);

  assign bus.w_en       = w_en_reg;
  assign bus.w_addr     = w_addr_reg;
  assign bus.w_data     = w_data_reg;
  assign bus.w_bank     = w_bank_reg;
  assign bus.frame_done = frame_done_reg;
  assign bus.sync_err   = sync_err_reg;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_reg      <= S_IDLE;
      color_reg      <= '0;
      angle_reg      <= '0;
      row_reg        <= '0;
      addr_reg       <= '0;
      w_en_reg       <= 1'b0;
      w_addr_reg     <= '0;
      w_data_reg     <= '0;
      w_bank_reg     <= 1'b0;
      frame_done_reg <= 1'b0;
      sync_err_reg   <= 1'b0;
    end else begin
      w_en_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
      sync_err_reg   <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (accept && bus.in_sof) begin
            w_en_reg   <= 1'b1;
            w_addr_reg <= '0;
            w_data_reg <= bus.in_data;
            color_reg  <= 2'd1;
            angle_reg  <= '0;
            row_reg    <= '0;
            addr_reg   <= ADDR_WIDTH'(1);
            state_reg  <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (accept) begin
            w_en_reg   <= 1'b1;
            w_data_reg <= bus.in_data;
            if (bus.in_sof) begin
              // Resynchronise: this beat becomes pixel 0 of a fresh frame.
              sync_err_reg <= 1'b1;
              w_addr_reg   <= '0;
              color_reg    <= 2'd1;
              angle_reg    <= '0;
              row_reg      <= '0;
              addr_reg     <= ADDR_WIDTH'(1);
            end else begin
              w_addr_reg <= addr_reg;
              if (last_beat) begin
                color_reg <= '0;
                angle_reg <= '0;
                row_reg   <= '0;
                addr_reg  <= '0;
                state_reg <= S_SWAP;
              end else begin
                addr_reg <= addr_reg + ADDR_WIDTH'(1);
                if (color_reg == 2'd2) begin
                  color_reg <= '0;
                  if (angle_reg == ANGLE_LAST) begin
                    angle_reg <= '0;
                    row_reg   <= row_reg + ROW_WIDTH'(1);
                  end else begin
                    angle_reg <= angle_reg + ANGLE_WIDTH'(1);
                  end
                end else begin
                  color_reg <= color_reg + 2'd1;
                end
              end
            end
          end
        end
        S_SWAP: begin
          // Entered one edge after the last write, so that write hits the old bank.
          if (!bus.bank_lock) begin
            w_bank_reg     <= ~w_bank_reg;
            frame_done_reg <= 1'b1;
            state_reg      <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_writer.sv
// Directed bench for frame_writer with a small 4-angle, 2-row frame (24 beats).
module tb_frame_writer;

  localparam int ADDR_WIDTH = 14;
  localparam int ROW_WIDTH  = 2;
  localparam int NB_ROWS    = 2;
  localparam int NB_ANGLES  = 4;
  localparam int DATA_WIDTH = 8;
  localparam int FRAME_BEATS = 3 * NB_ANGLES * NB_ROWS;

  logic clk;
  logic nrst;
  int   n_checks;
  int   n_errors;

  frame_writer_if #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

  frame_writer #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .ROW_WIDTH (ROW_WIDTH),
    .NB_ROWS   (NB_ROWS),
    .NB_ANGLES (NB_ANGLES),
    .DATA_WIDTH(DATA_WIDTH)
  ) dut (
    .clk (clk),
    .nrst(nrst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One beat presented for exactly one edge; outputs sampled 1 time unit later.
  task automatic send(input logic [7:0] d, input logic sof);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_sof   = sof;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    nrst          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.in_data   = '0;
    bus.bank_lock = 1'b0;
    repeat (3) tick();

    check("rst_w_en", 32'(bus.w_en), 32'd0);
    check("rst_w_addr", 32'(bus.w_addr), 32'd0);
    check("rst_w_data", 32'(bus.w_data), 32'd0);
    check("rst_w_bank", 32'(bus.w_bank), 32'd0);
    check("rst_frame_done", 32'(bus.frame_done), 32'd0);
    check("rst_sync_err", 32'(bus.sync_err), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    nrst = 1'b1;
    tick();

    // First three beats of a frame, then the rest of that frame.
    send(8'hAA, 1'b1);
    check("b0_w_en", 32'(bus.w_en), 32'd1);
    check("b0_w_addr", 32'(bus.w_addr), 32'd0);
    check("b0_w_data", 32'(bus.w_data), 32'hAA);
    send(8'h11, 1'b0);
    check("b1_w_addr", 32'(bus.w_addr), 32'd1);
    check("b1_w_data", 32'(bus.w_data), 32'h11);
    send(8'h22, 1'b0);
    check("b2_w_en", 32'(bus.w_en), 32'd1);
    check("b2_w_addr", 32'(bus.w_addr), 32'd2);
    check("b2_w_data", 32'(bus.w_data), 32'h22);
    check("b2_w_bank", 32'(bus.w_bank), 32'd0);
    for (int i = 3; i < FRAME_BEATS; i++) begin
      send(8'(8'h30 + i), 1'b0);
      check($sformatf("f1_addr%0d", i), 32'(bus.w_addr), 32'(i));
      check($sformatf("f1_data%0d", i), 32'(bus.w_data), 32'(8'h30 + i));
      check($sformatf("f1_bank%0d", i), 32'(bus.w_bank), 32'd0);
    end
    check("f1_swap_ready", 32'(bus.in_ready), 32'd0);
    check("f1_swap_no_done", 32'(bus.frame_done), 32'd0);
    tick();
    check("f1_bank_toggle", 32'(bus.w_bank), 32'd1);
    check("f1_frame_done", 32'(bus.frame_done), 32'd1);
    check("f1_no_w_en", 32'(bus.w_en), 32'd0);
    check("f1_idle_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check("f1_done_pulse", 32'(bus.frame_done), 32'd0);

    // Second frame with bank_lock held at the end.
    bus.bank_lock = 1'b1;
    send(8'h01, 1'b1);
    check("f2_addr0", 32'(bus.w_addr), 32'd0);
    for (int i = 1; i < FRAME_BEATS; i++) send(8'(i), 1'b0);
    check("f2_last_addr", 32'(bus.w_addr), 32'd23);
    check("f2_last_bank", 32'(bus.w_bank), 32'd1);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("lock_ready%0d", i), 32'(bus.in_ready), 32'd0);
      check($sformatf("lock_done%0d", i), 32'(bus.frame_done), 32'd0);
      check($sformatf("lock_bank%0d", i), 32'(bus.w_bank), 32'd1);
      tick();
    end
    bus.bank_lock = 1'b0;
    tick();
    check("unlock_bank", 32'(bus.w_bank), 32'd0);
    check("unlock_done", 32'(bus.frame_done), 32'd1);

    // Non-sof beats in IDLE are dropped.
    for (int i = 0; i < 5; i++) begin
      send(8'(8'hC0 + i), 1'b0);
      check($sformatf("idle_drop%0d", i), 32'(bus.w_en), 32'd0);
    end
    send(8'h55, 1'b1);
    check("idle_sof_en", 32'(bus.w_en), 32'd1);
    check("idle_sof_addr", 32'(bus.w_addr), 32'd0);

    // Mid-frame sof at address 7.
    for (int i = 1; i < 7; i++) send(8'(8'h60 + i), 1'b0);
    check("pre_sync_addr", 32'(bus.w_addr), 32'd6);
    check("pre_sync_err", 32'(bus.sync_err), 32'd0);
    send(8'h77, 1'b1);
    check("sync_err", 32'(bus.sync_err), 32'd1);
    check("sync_w_en", 32'(bus.w_en), 32'd1);
    check("sync_addr", 32'(bus.w_addr), 32'd0);
    check("sync_data", 32'(bus.w_data), 32'h77);
    send(8'h88, 1'b0);
    check("post_sync_err", 32'(bus.sync_err), 32'd0);
    check("post_sync_addr", 32'(bus.w_addr), 32'd1);
    check("post_sync_bank", 32'(bus.w_bank), 32'd0);
    check("post_sync_done", 32'(bus.frame_done), 32'd0);

    // Reset mid-frame with the next beat due at address 10.
    for (int i = 2; i < 10; i++) send(8'(8'h90 + i), 1'b0);
    check("pre_rst_addr", 32'(bus.w_addr), 32'd9);
    nrst = 1'b0;
    tick();
    check("mrst_w_en", 32'(bus.w_en), 32'd0);
    check("mrst_w_addr", 32'(bus.w_addr), 32'd0);
    check("mrst_w_data", 32'(bus.w_data), 32'd0);
    check("mrst_w_bank", 32'(bus.w_bank), 32'd0);
    check("mrst_sync_err", 32'(bus.sync_err), 32'd0);
    nrst = 1'b1;
    tick();
    send(8'h99, 1'b0);
    check("mrst_drop", 32'(bus.w_en), 32'd0);
    send(8'hAB, 1'b1);
    check("mrst_sof_en", 32'(bus.w_en), 32'd1);
    check("mrst_sof_addr", 32'(bus.w_addr), 32'd0);
    check("mrst_sof_data", 32'(bus.w_data), 32'hAB);
    send(8'hCD, 1'b0);
    check("mrst_next_addr", 32'(bus.w_addr), 32'd1);
    tick();
    check("idle_valid_low", 32'(bus.w_en), 32'd0);
    check("hold_addr", 32'(bus.w_addr), 32'd1);
    check("hold_data", 32'(bus.w_data), 32'hCD);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
